// File: rtl/dcfir_accum_pkg.sv
// Shared D-CFIR definitions: data width, accumulator FSM states and the
// round-shift-saturate helper used to bring wide sums back to DATA_W bits.
package dcfir_accum_pkg;

   localparam int DATA_W = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              sat;
   } rs_t;

   // raw holds an acc_w-bit two's-complement value in its low bits; it is
   // sign-extended to 64 bits so the rounding add can never overflow.
   // Rounding adds half an output LSB before the arithmetic shift, which
   // rounds ties toward +infinity.
   function automatic rs_t round_sat(input logic [63:0] raw,
                                     input int          acc_w,
                                     input int          shift);
      logic signed [63:0] v_ext;
      logic signed [63:0] v_rnd;
      rs_t                v_out;
      v_ext = $signed(raw << (64 - acc_w)) >>> (64 - acc_w);
      v_rnd = v_ext + ((shift > 0) ? (64'sd1 <<< (shift - 1)) : 64'sd0);
      v_rnd = v_rnd >>> shift;
      if (v_rnd > 64'sd32767) begin
         v_out.data = 16'h7FFF;
         v_out.sat  = 1'b1;
      end else if (v_rnd < -64'sd32768) begin
         v_out.data = 16'h8000;
         v_out.sat  = 1'b1;
      end else begin
         v_out.data = v_rnd[DATA_W-1:0];
         v_out.sat  = 1'b0;
      end
      return v_out;
   endfunction

endpackage

// File: rtl/dcfir_round_sat.sv
// Combinational ACC_W -> DATA_W round, arithmetic shift and saturate for
// one component (real or imaginary) of a completed FIR sample.
module dcfir_round_sat
   import dcfir_accum_pkg::*;
#(
   parameter int ACC_W     = 24,
   parameter int OUT_SHIFT = 2
) (
   input  logic signed [ACC_W-1:0]  i_acc,
   output logic        [DATA_W-1:0] o_data,
   output logic                     o_sat
);

   rs_t w_rs;

   // Whole conversion lives in the shared helper so both components match.
   always_comb begin
      w_rs = round_sat(64'(i_acc), ACC_W, OUT_SHIFT);
   end

   assign o_data = w_rs.data;
   assign o_sat  = w_rs.sat;

endmodule

// File: rtl/dcfir_accum.sv
// Phase accumulator after the D-CFIR VMM stage: sums NUM_PHASES complex
// partials per output sample, checks first/last framing, and emits a
// rounded, shifted, saturated 16-bit complex result.
//
// Handshake: in_valid qualifies in_first/in_last/in_real/in_imag for one
// cycle; there is no ready, the block accepts every valid beat. out_valid
// and err_framing are single-cycle pulses, one cycle after the causing beat.
module dcfir_accum
   import dcfir_accum_pkg::*;
#(
   parameter int NUM_PHASES = 8,
   parameter int ACC_W      = 24,
   parameter int OUT_SHIFT  = 2
) (
   input  logic                     CLK,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic                     in_first,
   input  logic                     in_last,
   input  logic signed [DATA_W-1:0] in_real,
   input  logic signed [DATA_W-1:0] in_imag,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] out_real,
   output logic signed [DATA_W-1:0] out_imag,
   output logic                     out_sat,
   output logic                     err_framing
);

   localparam int CNT_W = $clog2(NUM_PHASES) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PHASES - 1);

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [CNT_W-1:0]         r_cnt;
   logic [CNT_W-1:0]         w_cnt_nxt;
   logic signed [ACC_W-1:0]  r_acc_re;
   logic signed [ACC_W-1:0]  r_acc_im;
   logic signed [ACC_W-1:0]  w_acc_re_nxt;
   logic signed [ACC_W-1:0]  w_acc_im_nxt;
   logic signed [ACC_W-1:0]  w_in_re;
   logic signed [ACC_W-1:0]  w_in_im;
   logic signed [ACC_W-1:0]  w_sum_re;
   logic signed [ACC_W-1:0]  w_sum_im;
   logic                     w_restart;
   logic                     w_emit;
   logic                     w_err;
   logic [DATA_W-1:0]        w_rs_re;
   logic [DATA_W-1:0]        w_rs_im;
   logic                     w_sat_re;
   logic                     w_sat_im;

   assign w_in_re = {{(ACC_W-DATA_W){in_real[DATA_W-1]}}, in_real};
   assign w_in_im = {{(ACC_W-DATA_W){in_imag[DATA_W-1]}}, in_imag};

   // A first beat (or any beat while idle) starts from zero rather than
   // from the running sum, so the same adder serves start and continue.
   assign w_restart = in_first || (r_state == IDLE);
   assign w_sum_re  = (w_restart ? '0 : r_acc_re) + w_in_re;
   assign w_sum_im  = (w_restart ? '0 : r_acc_im) + w_in_im;

   dcfir_round_sat #(
      .ACC_W     (ACC_W),
      .OUT_SHIFT (OUT_SHIFT)
   ) u_rs_re (
      .i_acc  (w_sum_re),
      .o_data (w_rs_re),
      .o_sat  (w_sat_re)
   );

   dcfir_round_sat #(
      .ACC_W     (ACC_W),
      .OUT_SHIFT (OUT_SHIFT)
   ) u_rs_im (
      .i_acc  (w_sum_im),
      .o_data (w_rs_im),
      .o_sat  (w_sat_im)
   );

   // Next-state, counter, accumulator and pulse decisions for each beat.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_acc_re_nxt = r_acc_re;
      w_acc_im_nxt = r_acc_im;
      w_emit       = 1'b0;
      w_err        = 1'b0;
      if (in_valid) begin
         unique case (r_state)
            IDLE: begin
               // Beats without first while idle are dropped silently.
               if (in_first) begin
                  if (in_last && (NUM_PHASES == 1)) begin
                     w_emit = 1'b1;
                  end else begin
                     // first+last on a multi-phase frame is a restart
                     // that is also flagged.
                     w_err        = in_last;
                     w_state_nxt  = ACCUM;
                     w_cnt_nxt    = CNT_ONE;
                     w_acc_re_nxt = w_sum_re;
                     w_acc_im_nxt = w_sum_im;
                  end
               end
            end
            ACCUM: begin
               if (in_first) begin
                  // Unexpected first: flag and restart, even with in_last.
                  w_err        = 1'b1;
                  w_cnt_nxt    = CNT_ONE;
                  w_acc_re_nxt = w_sum_re;
                  w_acc_im_nxt = w_sum_im;
               end else if (in_last) begin
                  if (r_cnt == CNT_LAST) begin
                     w_emit = 1'b1;
                  end else begin
                     w_err = 1'b1;
                  end
                  w_state_nxt  = IDLE;
                  w_cnt_nxt    = '0;
                  w_acc_re_nxt = '0;
                  w_acc_im_nxt = '0;
               end else if (r_cnt >= CNT_LAST) begin
                  // This beat fills the frame without a last marker.
                  w_err        = 1'b1;
                  w_state_nxt  = IDLE;
                  w_cnt_nxt    = '0;
                  w_acc_re_nxt = '0;
                  w_acc_im_nxt = '0;
               end else begin
                  w_cnt_nxt    = r_cnt + 1'b1;
                  w_acc_re_nxt = w_sum_re;
                  w_acc_im_nxt = w_sum_im;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   // FSM state, phase counter and accumulators.
   always_ff @(posedge CLK) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_acc_re <= '0;
         r_acc_im <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_acc_re <= w_acc_re_nxt;
         r_acc_im <= w_acc_im_nxt;
      end
   end

   // Registered result and status pulses; the sample holds until the next emit.
   always_ff @(posedge CLK) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_real    <= '0;
         out_imag    <= '0;
         out_sat     <= 1'b0;
         err_framing <= 1'b0;
      end else begin
         out_valid   <= w_emit;
         out_sat     <= w_emit & (w_sat_re | w_sat_im);
         err_framing <= w_err;
         if (w_emit) begin
            out_real <= w_rs_re;
            out_imag <= w_rs_im;
         end
      end
   end

endmodule

// File: tb/tb_dcfir_accum.sv
// Bench for dcfir_accum: directed frames plus randomized framing stress,
// checked by a scoreboard fed from a frame-level reference model.
module tb_dcfir_accum;

   localparam int NP    = 8;
   localparam int ACCW  = 24;
   localparam int SHIFT = 2;

   logic               CLK = 1'b0;
   logic               rst = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_first = 1'b0;
   logic               in_last = 1'b0;
   logic signed [15:0] in_real = '0;
   logic signed [15:0] in_imag = '0;
   logic               out_valid;
   logic signed [15:0] out_real;
   logic signed [15:0] out_imag;
   logic               out_sat;
   logic               err_framing;

   dcfir_accum #(
      .NUM_PHASES (NP),
      .ACC_W      (ACCW),
      .OUT_SHIFT  (SHIFT)
   ) dut (
      .CLK         (CLK),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_first    (in_first),
      .in_last     (in_last),
      .in_real     (in_real),
      .in_imag     (in_imag),
      .out_valid   (out_valid),
      .out_real    (out_real),
      .out_imag    (out_imag),
      .out_sat     (out_sat),
      .err_framing (err_framing)
   );

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   int   edge_n = 0;
   logic rst_q  = 1'b1;
   always @(posedge CLK) begin
      edge_n++;
      rst_q <= rst;
   end

   // ---------------- scoreboard state ----------------
   // exp_q entry: {edge stamp[31:0], real[15:0], imag[15:0], sat}
   logic [64:0] exp_q[$];
   logic [31:0] err_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] hold_re = '0;
   logic [15:0] hold_im = '0;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Frame-level view: collect the partials of the open frame, and when a
   // frame closes correctly sum them and scale with real arithmetic.
   bit in_frame = 1'b0;
   int fre[$];
   int fim[$];

   function automatic int scale_clip(input int s, output bit clipped);
      real q;
      int  r;
      q = $floor(real'(s) / real'(1 << SHIFT) + 0.5);
      r = int'(q);
      clipped = 1'b0;
      if (r > 32767) begin
         r = 32767;
         clipped = 1'b1;
      end else if (r < -32768) begin
         r = -32768;
         clipped = 1'b1;
      end
      return r;
   endfunction

   task automatic model_emit(input int stamp);
      int sr = 0;
      int si = 0;
      int rr;
      int ri;
      bit cr;
      bit ci;
      foreach (fre[k]) sr += fre[k];
      foreach (fim[k]) si += fim[k];
      rr = scale_clip(sr, cr);
      ri = scale_clip(si, ci);
      exp_q.push_back({32'(stamp), 16'(rr), 16'(ri), cr | ci});
   endtask

   task automatic model_beat(input bit f, input bit l, input logic [15:0] re,
                             input logic [15:0] im, input int stamp);
      if (f) begin
         if (in_frame || (l && NP != 1)) err_q.push_back(32'(stamp));
         fre.delete();
         fim.delete();
         fre.push_back(int'($signed(re)));
         fim.push_back(int'($signed(im)));
         if (!in_frame && l && NP == 1) begin
            model_emit(stamp);
            in_frame = 1'b0;
         end else begin
            in_frame = 1'b1;
         end
      end else if (in_frame) begin
         fre.push_back(int'($signed(re)));
         fim.push_back(int'($signed(im)));
         if (l) begin
            if (fre.size() == NP) model_emit(stamp);
            else err_q.push_back(32'(stamp));
            in_frame = 1'b0;
         end else if (fre.size() == NP) begin
            err_q.push_back(32'(stamp));
            in_frame = 1'b0;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic beat(input bit v, input bit f, input bit l,
                       input logic [15:0] re, input logic [15:0] im, input bit r);
      @(posedge CLK);
      #1;
      rst      = r;
      in_valid = v;
      in_first = f;
      in_last  = l;
      in_real  = re;
      in_imag  = im;
      if (r) in_frame = 1'b0;
      else if (v) model_beat(f, l, re, im, edge_n + 1);
   endtask

   task automatic idle(input int n);
      repeat (n) beat(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
   endtask

   // n beats; first beat carries re0/im0, the rest re/im (or random values).
   task automatic frame(input int n, input bit with_last, input logic [15:0] re0,
                        input logic [15:0] im0, input logic [15:0] re,
                        input logic [15:0] im, input bit rnd, input int max_gap);
      logic [15:0] vr;
      logic [15:0] vi;
      for (int i = 0; i < n; i++) begin
         if (i > 0 && max_gap > 0) idle($urandom_range(0, max_gap));
         vr = (i == 0) ? re0 : re;
         vi = (i == 0) ? im0 : im;
         if (rnd) begin
            vr = 16'($urandom_range(0, 65535));
            vi = 16'($urandom_range(0, 65535));
         end
         beat(1'b1, i == 0, with_last && (i == n - 1), vr, vi, 1'b0);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge CLK) begin
      logic [64:0] e;
      logic [31:0] es;
      if (rst_q) begin
         hold_re = '0;
         hold_im = '0;
      end
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected out_valid", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("out_valid timing", edge_n, longint'(e[64:33]));
            check("out_real", $signed(out_real), $signed(e[32:17]));
            check("out_imag", $signed(out_imag), $signed(e[16:1]));
            check("out_sat", out_sat, e[0]);
            hold_re = e[32:17];
            hold_im = e[16:1];
         end
      end else begin
         check("out_real hold", $signed(out_real), $signed(hold_re));
         check("out_imag hold", $signed(out_imag), $signed(hold_im));
      end
      if (err_framing) begin
         if (err_q.size() == 0) begin
            check("unexpected err_framing", 1, 0);
         end else begin
            es = err_q.pop_front();
            check("err_framing timing", edge_n, longint'(es));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("reset out_valid", out_valid, 0);
      check("reset out_real", out_real, 0);
      check("reset out_imag", out_imag, 0);
      check("reset out_sat", out_sat, 0);
      check("reset err_framing", err_framing, 0);

      // Basic frame: 100/-100 x8 -> 200/-200
      frame(NP, 1'b1, 16'd100, -16'sd100, 16'd100, -16'sd100, 1'b0, 0);
      idle(2);
      // Saturation: 20000/-20000 x8 -> clipped both ways
      frame(NP, 1'b1, 16'd20000, -16'sd20000, 16'd20000, -16'sd20000, 1'b0, 0);
      idle(2);
      // Rounding: sums 6 / -6 -> 2 / -1
      frame(NP, 1'b1, 16'd6, -16'sd6, 16'd0, 16'd0, 1'b0, 0);
      idle(2);
      // Stray non-first beats while idle are ignored
      beat(1'b1, 1'b0, 1'b0, 16'd5, 16'd5, 1'b0);
      beat(1'b1, 1'b0, 1'b1, 16'd5, 16'd5, 1'b0);
      idle(1);
      // Early last on beat 5
      frame(5, 1'b1, 16'd7, 16'd7, 16'd7, 16'd7, 1'b0, 0);
      idle(2);
      // First on beat 4, then a clean frame
      frame(3, 1'b0, 16'd9, 16'd9, 16'd9, 16'd9, 1'b0, 0);
      frame(NP, 1'b1, 16'd300, 16'd40, 16'd300, 16'd40, 1'b0, 0);
      idle(2);
      // Overrun: no last within NUM_PHASES beats
      frame(NP + 1, 1'b0, 16'd1, 16'd1, 16'd1, 16'd1, 1'b0, 0);
      idle(2);
      // first+last together mid-frame, then a clean frame
      frame(2, 1'b0, 16'd3, 16'd3, 16'd3, 16'd3, 1'b0, 0);
      beat(1'b1, 1'b1, 1'b1, 16'd3, 16'd3, 1'b0);
      idle(1);
      frame(NP, 1'b1, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 0);
      // Bubbles inside frames and back-to-back frames
      for (int f = 0; f < 6; f++) frame(NP, 1'b1, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 2);
      for (int f = 0; f < 3; f++) frame(NP, 1'b1, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 0);
      idle(2);
      // Reset on the 6th beat, then a clean frame right after release
      frame(5, 1'b0, 16'd50, 16'd50, 16'd50, 16'd50, 1'b0, 0);
      beat(1'b1, 1'b0, 1'b0, 16'd50, 16'd50, 1'b1);
      frame(NP, 1'b1, -16'sd1234, 16'd777, -16'sd1234, 16'd777, 1'b0, 0);
      idle(2);
      // Random framing stress
      for (int i = 0; i < 300; i++) begin
         beat($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 7) == 0, 16'($urandom_range(0, 65535)),
              16'($urandom_range(0, 65535)), 1'b0);
      end
      for (int f = 0; f < 4; f++) frame(NP, 1'b1, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1);
      idle(6);

      check("exp_q drained", exp_q.size(), 0);
      check("err_q drained", err_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dcfir_accum.md
# dcfir_accum

Phase accumulator downstream of the time-multiplexed D-CFIR vector-matrix stage. Each cycle the VMM stage produces one complex partial sum covering 4 taps for the current `sel` phase. This block adds NUM_PHASES consecutive partials into one complex FIR output sample, then rounds, shifts and saturates it back to 16 bits. It also checks frame markers and flags framing errors.

## Interface
Parameters:
- NUM_PHASES, 8: partial sums per output sample (8 × 4 taps = 32 taps).
- ACC_W, 24: accumulator width. Must be ≥ 16 + clog2(NUM_PHASES) + 1.
- OUT_SHIFT, 2: arithmetic right shift applied at frame end. Legal range 0..ACC_W-16.

Ports:
- CLK, input, 1: sole clock, rising edge.
- rst, input, 1: reset, synchronous, active-high.
- in_valid, input, 1: partial sum present this cycle.
- in_first, input, 1: first phase of a frame. Qualified by in_valid.
- in_last, input, 1: last phase of a frame. Qualified by in_valid.
- in_real, input, 16: signed two's-complement partial, real part.
- in_imag, input, 16: signed two's-complement partial, imaginary part.
- out_valid, output, 1: one-cycle pulse; out_real/out_imag hold a completed sample.
- out_real, output, 16: signed result, real part.
- out_imag, output, 16: signed result, imaginary part.
- out_sat, output, 1: high with out_valid if either component was clipped.
- err_framing, output, 1: one-cycle pulse on any framing violation.

## Operation
- FSM has two states: IDLE and ACCUM. A phase counter `cnt` runs 0..NUM_PHASES-1.
- In IDLE:
  - Beat with in_valid & in_first: acc ← sign-extend(in), cnt ← 1, go to ACCUM.
  - Beat with in_valid & ~in_first: ignored. No error.
- In ACCUM, a beat with in_valid & ~in_first & ~in_last:
  - acc ← acc + in, cnt ← cnt+1.
  - If this beat makes cnt reach NUM_PHASES (no last seen): pulse err_framing, go to IDLE, discard the frame.
- In ACCUM, a beat with in_valid & in_last:
  - If cnt == NUM_PHASES-1: compute final = acc + in, emit the result, go to IDLE.
  - Otherwise: pulse err_framing, discard, go to IDLE.
- In ACCUM, a beat with in_valid & in_first:
  - Pulse err_framing and restart: acc ← in, cnt ← 1, stay in ACCUM.
  - This applies even if in_last is also set.
- in_first & in_last on the same beat:
  - NUM_PHASES == 1: a legal one-beat frame.
  - Otherwise: treated as an in_first restart plus err_framing pulse.
- Cycles with in_valid low are bubbles. acc and cnt hold; there is no timeout.
- Result arithmetic, applied independently to real and imaginary parts:
  - r = (final + (OUT_SHIFT ? 2^(OUT_SHIFT-1) : 0)) >>> OUT_SHIFT. This rounds half toward +∞.
  - Saturate r to [-32768, 32767].
  - out_sat = either component clipped.
- Accumulation never wraps when ACC_W meets the parameter rule.

## Timing
- Reset values: out_valid=0, out_real=0, out_imag=0, out_sat=0, err_framing=0, state=IDLE, cnt=0, acc=0.
- Latency: out_valid, out_real, out_imag and out_sat are registered. They update on the edge that samples the in_last beat, so they are visible the cycle after that beat.
- out_real/out_imag hold their value until the next out_valid.
- err_framing is registered and asserts the cycle after the offending beat.
- Back-to-back frames are legal: in_first may arrive the cycle immediately after in_last. Throughput is one sample per NUM_PHASES valid beats, with no dead cycle.
- rst asserted mid-frame discards the partial frame, with no out_valid and no err_framing. The first cycle after rst deasserts accepts in_first.
- No backpressure; the block is always ready.

## Structure
- The shared D-CFIR package holds:
  - DATA_W=16.
  - A saturate/round function taking a width parameter.
  - An FSM state enum {IDLE, ACCUM}.
- One sub-module, `dcfir_round_sat`: the combinational ACC_W→16 round-shift-saturate, instantiated once per component.
- The FSM, counter and accumulators live in the top-level block.

## Test plan
All scenarios use default parameters (NUM_PHASES=8, OUT_SHIFT=2).
- Basic frame: 8 beats of in_real=100, in_imag=-100 → one cycle after last, out_valid=1, out_real=200, out_imag=-200, out_sat=0.
- Saturation: 8 beats of real=20000, imag=-20000 → out_real=32767, out_imag=-32768, out_sat=1.
- Rounding: partials sum to real=6, imag=-6 → out_real=2, out_imag=-1.
- Framing errors:
  - in_last on the 5th beat → err_framing pulse, no out_valid.
  - in_first on the 4th beat, then 8 clean beats → one err_framing pulse, then a correct sample.
- Bubbles and back-to-back: random in_valid gaps inside the frame and a second frame starting right after in_last → both samples correct, out_valid pulses exactly NUM_PHASES valid beats apart.
- Reset mid-frame: rst on the 6th beat, then a clean frame → only the clean frame produces out_valid, and its value is correct.
